// File: rtl/cordic_pkg.sv
// Shared constants, angle tables and FSM state type for the CORDIC sin/cos unit.
package cordic_pkg;

   localparam int ONE_Q12     = 4096;
   localparam int PI_Q12      = 12868;
   localparam int HALF_PI_Q12 = 6434;

   // Inverse CORDIC gain for 14 micro-rotations, Q16
   localparam int K_Q16 = 39797;

   // round(atan(2^-i) * 65536)
   localparam int ATAN_Q16 [16] = '{
      51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
      256,   128,   64,    32,   16,   8,    4,    2
   };

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ROT,
      STORE,
      DONE
   } state_e;

   function automatic logic out_of_range(input logic signed [15:0] a);
      return (int'(a) > PI_Q12) || (int'(a) < -PI_Q12);
   endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// One combinational CORDIC micro-rotation in rotation mode (drives z towards 0).
module cordic_rot_step
   import cordic_pkg::*;
#(
   parameter int IW = 20
) (
   input  logic signed [IW-1:0] x_i,
   input  logic signed [IW-1:0] y_i,
   input  logic signed [IW-1:0] z_i,
   input  logic        [3:0]    i_i,
   output logic signed [IW-1:0] x_o,
   output logic signed [IW-1:0] y_o,
   output logic signed [IW-1:0] z_o
);

   logic signed [IW-1:0] x_sh;
   logic signed [IW-1:0] y_sh;
   logic signed [IW-1:0] atan_i;

   always_comb begin
      x_sh   = x_i >>> i_i;
      y_sh   = y_i >>> i_i;
      atan_i = IW'(ATAN_Q16[i_i]);
      if (z_i[IW-1]) begin
         x_o = x_i + y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + atan_i;
      end else begin
         x_o = x_i - y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - atan_i;
      end
   end

endmodule

// File: rtl/cordic_sincos3.sv
// Three-angle sin/cos unit: one shared CORDIC stage walks ang1, ang2, ang3 in turn.
// Optional: define SINCOS_SAT_EN to clamp stored results to [-4096, 4096].
module cordic_sincos3
   import cordic_pkg::*;
#(
   parameter int ITER = 14,
   parameter int IW   = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [15:0] ang1,
   input  logic signed [15:0] ang2,
   input  logic signed [15:0] ang3,
   output logic               busy,
   output logic               done,
   output logic signed [15:0] cos1,
   output logic signed [15:0] sin1,
   output logic signed [15:0] cos2,
   output logic signed [15:0] sin2,
   output logic signed [15:0] cos3,
   output logic signed [15:0] sin3,
   output logic               range_err
);

   state_e               state_q;
   logic [1:0]           idx_q;
   logic [3:0]           cnt_q;
   logic signed [15:0]   ang_q [3];
   logic                 err_q;
   logic signed [IW-1:0] x_q, y_q, z_q;
   logic                 neg_q;
   logic signed [15:0]   cos_q [3];
   logic signed [15:0]   sin_q [3];
   logic                 busy_q, done_q, range_err_q;

   logic signed [15:0]   ang_sel, ang_clamp, ang_fold;
   logic                 neg_d;
   logic signed [IW-1:0] x_d, y_d, z_d;
   logic signed [IW-1:0] x_s, y_s, z_s;
   logic signed [15:0]   cos_d, sin_d;

   function automatic logic signed [15:0] to_q12(input logic signed [IW-1:0] v);
      logic signed [IW-1:0] r;
      r = (v + IW'(8)) >>> 4;
`ifdef SINCOS_SAT_EN
      if (r > IW'(ONE_Q12))
         r = IW'(ONE_Q12);
      else if (r < -IW'(ONE_Q12))
         r = -IW'(ONE_Q12);
`endif
      return r[15:0];
   endfunction

   cordic_rot_step #(.IW(IW)) u_step (
      .x_i (x_q),
      .y_i (y_q),
      .z_i (z_q),
      .i_i (cnt_q),
      .x_o (x_s),
      .y_o (y_s),
      .z_o (z_s)
   );

   // Clamp to +-pi, then fold the outer quadrants onto +-pi/2 using
   // cos(a) = -cos(a -+ pi), sin(a) = -sin(a -+ pi).
   always_comb begin
      case (idx_q)
         2'd0:    ang_sel = ang_q[0];
         2'd1:    ang_sel = ang_q[1];
         default: ang_sel = ang_q[2];
      endcase

      ang_clamp = ang_sel;
      if (int'(ang_sel) > PI_Q12)
         ang_clamp = 16'(PI_Q12);
      else if (int'(ang_sel) < -PI_Q12)
         ang_clamp = 16'(-PI_Q12);

      ang_fold = ang_clamp;
      neg_d    = 1'b0;
      if (int'(ang_clamp) > HALF_PI_Q12) begin
         ang_fold = ang_clamp - 16'(PI_Q12);
         neg_d    = 1'b1;
      end else if (int'(ang_clamp) < -HALF_PI_Q12) begin
         ang_fold = ang_clamp + 16'(PI_Q12);
         neg_d    = 1'b1;
      end
   end

   always_comb begin
      if (state_q == PREP) begin
         x_d = IW'(K_Q16);
         y_d = '0;
         z_d = IW'(ang_fold) <<< 4;
      end else begin
         x_d = x_s;
         y_d = y_s;
         z_d = z_s;
      end
      cos_d = to_q12(neg_q ? -x_q : x_q);
      sin_d = to_q12(neg_q ? -y_q : y_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         neg_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         range_err_q <= 1'b0;
         for (int k = 0; k < 3; k++) begin
            ang_q[k] <= '0;
            cos_q[k] <= '0;
            sin_q[k] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  ang_q[0]    <= ang1;
                  ang_q[1]    <= ang2;
                  ang_q[2]    <= ang3;
                  err_q       <= out_of_range(ang1) | out_of_range(ang2) | out_of_range(ang3);
                  range_err_q <= 1'b0;
                  busy_q      <= 1'b1;
                  idx_q       <= '0;
                  state_q     <= PREP;
               end
            end
            PREP: begin
               x_q     <= x_d;
               y_q     <= y_d;
               z_q     <= z_d;
               neg_q   <= neg_d;
               cnt_q   <= '0;
               state_q <= ROT;
            end
            ROT: begin
               x_q   <= x_d;
               y_q   <= y_d;
               z_q   <= z_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'(ITER - 1))
                  state_q <= STORE;
            end
            STORE: begin
               case (idx_q)
                  2'd0: begin
                     cos_q[0] <= cos_d;
                     sin_q[0] <= sin_d;
                  end
                  2'd1: begin
                     cos_q[1] <= cos_d;
                     sin_q[1] <= sin_d;
                  end
                  default: begin
                     cos_q[2] <= cos_d;
                     sin_q[2] <= sin_d;
                  end
               endcase
               if (idx_q == 2'd2) begin
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  range_err_q <= err_q;
                  state_q     <= DONE;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= PREP;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign range_err = range_err_q;
   assign cos1      = cos_q[0];
   assign sin1      = sin_q[0];
   assign cos2      = cos_q[1];
   assign sin2      = sin_q[1];
   assign cos3      = cos_q[2];
   assign sin3      = sin_q[2];

endmodule
